// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous square
// wave in clock cycles. A valid pulse marks each completed period; a sticky
// timeout flag reports a counter that saturated before the next rising edge.
module period_meter #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    ARMED   = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // Two-flop synchronizer plus a history flop for edge detection; runs regardless of enable.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // State, counter and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= ARMED;
      cnt_q       <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_cnt_q  <= high_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic: a rise beats saturation, and disable beats everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_cnt_d  = high_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!enable) begin
      state_d    = ARMED;
      cnt_d      = '0;
      high_cnt_d = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (rise) begin
            cnt_d      = CNT_ONE;
            high_cnt_d = '0;
            state_d    = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = high_cnt_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = CNT_ONE;
            high_cnt_d  = '0;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d  = 1'b1;
            state_d    = ARMED;
            cnt_d      = '0;
            high_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) begin
              high_cnt_d = cnt_q;
            end
          end
        end
        default: state_d = ARMED;
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives square waves into period_meter and checks every
// cycle against a timestamp-based model of the measurement rules.
module tb_period_meter;

  localparam int unsigned W   = 8;
  localparam int          MAX = (1 << W) - 1;

  logic         clock;
  logic         clear;
  logic         enable;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  int tests_run = 0;
  int tests_failed = 0;

  period_meter #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: remembers input samples and the edge index of the
  // measurement's rise/fall, and derives outputs from elapsed edge counts.
  bit sh [3];          // sh[0] = sample one edge ago, sh[1] two ago, sh[2] three ago
  int n;               // edge index since clear
  bit armed;
  int t_rise, t_fall;
  bit fall_seen;
  int exp_period, exp_high;
  bit exp_valid, exp_timeout;

  always @(posedge clock) begin
    bit lvl, prev, r, f;
    int el;
    if (clear) begin
      sh = '{0, 0, 0};
      n = 0;
      armed = 1;
      fall_seen = 0;
      t_rise = 0;
      t_fall = 0;
      exp_period = 0;
      exp_high = 0;
      exp_valid = 0;
      exp_timeout = 0;
    end else begin
      // The synchronised level seen now is the input from two edges ago.
      lvl  = sh[1];
      prev = sh[2];
      r = lvl & !prev;
      f = !lvl & prev;
      exp_valid = 0;
      if (!enable) begin
        armed = 1;
      end else if (armed) begin
        if (r) begin
          armed = 0;
          t_rise = n;
          fall_seen = 0;
        end
      end else begin
        el = n - t_rise;
        if (r) begin
          exp_period = el;
          exp_high = fall_seen ? (t_fall - t_rise) : 0;
          exp_valid = 1;
          exp_timeout = 0;
          t_rise = n;
          fall_seen = 0;
        end else if (el == MAX) begin
          exp_timeout = 1;
          armed = 1;
        end else if (f) begin
          fall_seen = 1;
          t_fall = n;
        end
      end
      sh[2] = sh[1];
      sh[1] = sh[0];
      sh[0] = sig_in;
      n++;
    end
    #1;
    chk("valid", {31'd0, valid}, {31'd0, exp_valid});
    chk("timeout", {31'd0, timeout}, {31'd0, exp_timeout});
    chk("period", {24'd0, period}, exp_period);
    chk("high_time", {24'd0, high_time}, exp_high);
  end

  // Counts valid pulses so phases can confirm measurements actually happened.
  int valid_count = 0;
  always @(negedge clock) if (valid === 1'b1) valid_count++;

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge clock);
      sig_in = 1'b0;
      repeat (lo) @(negedge clock);
    end
  endtask

  task automatic pin(input string nm, input int p, input int h, input bit t);
    chk({nm, "_period"}, {24'd0, period}, p);
    chk({nm, "_high"}, {24'd0, high_time}, h);
    chk({nm, "_timeout"}, {31'd0, timeout}, {31'd0, t});
  endtask

  initial begin
    int vc;
    clear = 1'b1;
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (2) @(negedge clock);
    pin("reset", 0, 0, 0);
    chk("reset_valid", {31'd0, valid}, 0);
    clear = 1'b0;

    // 2 high / 3 low
    vc = valid_count;
    wave(2, 3, 8);
    pin("w2_3", 5, 2, 0);
    chk("w2_3_count", valid_count - vc, 7);

    // 7 high / 13 low
    wave(7, 13, 4);
    pin("w7_13", 20, 7, 0);

    // One rise then a long low: saturates
    vc = valid_count;
    wave(7, 300, 1);
    pin("sat", 20, 7, 1);
    chk("sat_valid_count", valid_count - vc, 1);

    // 4/4 recovers
    wave(4, 4, 6);
    pin("w4_4", 8, 4, 0);

    // Async clear in the low phase of a 10-cycle wave
    wave(5, 5, 3);
    pin("pre_clr", 10, 5, 0);
    sig_in = 1'b1;
    repeat (5) @(negedge clock);
    sig_in = 1'b0;
    @(posedge clock);
    #2 clear = 1'b1;
    #1;
    pin("clr", 0, 0, 0);
    chk("clr_valid", {31'd0, valid}, 0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    repeat (3) @(negedge clock);
    vc = valid_count;
    wave(5, 5, 1);
    chk("clr_no_valid_first_rise", valid_count - vc, 0);
    wave(5, 5, 3);
    pin("post_clr", 10, 5, 0);

    // Enable dropped for one cycle during a high phase
    sig_in = 1'b1;
    repeat (2) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    repeat (2) @(negedge clock);
    sig_in = 1'b0;
    repeat (5) @(negedge clock);
    wave(5, 5, 4);
    pin("en_drop", 10, 5, 0);

    // 1/1 fastest wave
    wave(1, 1, 10);
    pin("w1_1", 2, 1, 0);

    // Randomized waves with occasional long lows and enable drops
    for (int it = 0; it < 30; it++) begin
      int hi, lo, d;
      hi = $urandom_range(1, 20);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 20);
      sig_in = 1'b1;
      repeat (hi) @(negedge clock);
      sig_in = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        d = $urandom_range(1, 3);
        enable = 1'b0;
        repeat (d) @(negedge clock);
        enable = 1'b1;
        lo = (lo > d) ? lo - d : 1;
      end
      repeat (lo) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
